bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_SLAVES, default 3: number of slave ports whose split signals are monitored.
REQ-002 Parameter NUM_MASTERS, fixed at 2 (localparam): number of requesting masters.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rstn  input  1  reset; asynchronous and active-low.
REQ-005 mreq  input  2  per-master bus request, held high for the whole transaction, dropped to release.
REQ-006 mgrant  output  2  per-master bus grant, registered, one-hot or zero.
REQ-007 msel  output  1  index of the granted master, for the bus mux; holds its last value when no grant is active.
REQ-008 msplit  output  2  per-master flag, high while that master's transaction is split and pending.
REQ-009 ssplit  input  NUM_SLAVES  per-slave split indicator, high while the slave is fetching split read data.
REQ-010 split_grant  output  NUM_SLAVES  per-slave one-cycle pulse permitting the split slave to return read data.
REQ-011 split_err  output  1  one-cycle pulse when a second split is attempted while one is pending.

Function
REQ-012 The state machine SHALL have the states IDLE, BUSY and SPLIT_RET.
REQ-013 IDLE: if split_ready is set, go to SPLIT_RET; else if any unmasked mreq is high, grant by round-robin starting after rr_last, then go to BUSY; else stay in IDLE.
REQ-014 The grant SHALL appear on mgrant one cycle after the request is sampled in IDLE.
REQ-015 BUSY: if mreq[owner] is low, clear mgrant next cycle and go to IDLE, which costs one turnaround cycle before any new grant.
REQ-016 BUSY: on a rising edge of ssplit[k] with no split pending, next cycle clear mgrant[owner], set msplit[owner], store split_owner=owner and split_slave=k, set split_pending, and go to IDLE.
REQ-017 While split_pending is set, mreq[split_owner] SHALL be masked from arbitration.
REQ-018 A falling edge of ssplit[split_slave] while split_pending is set SHALL set split_ready.
REQ-019 SPLIT_RET (one cycle): assert mgrant[split_owner], pulse split_grant[split_slave], clear msplit, split_pending and split_ready, then go to BUSY with owner=split_owner.
REQ-020 If split_ready is set while another master is BUSY, the split return SHALL wait until that master releases; the BUSY owner is never pre-empted.
REQ-021 If split_ready and new requests occur together in IDLE, the split return SHALL have priority.
REQ-022 A rising edge of ssplit from any slave while split_pending is set SHALL pulse split_err and be otherwise ignored (one outstanding split only).
REQ-023 rr_last SHALL update to the granted master on every grant, including a SPLIT_RET grant.
REQ-024 Edge detection SHALL use registered ssplit (ssplit_q); ssplit edges from slaves other than the current owner's target are not qualified by address.

Reset
REQ-025 On rstn low, all of the following SHALL clear asynchronously to 0: state=IDLE, mgrant, msel, msplit, split_grant, split_err, split_pending, split_ready, split_owner, split_slave, rr_last, ssplit_q.
REQ-026 After reset, master 0 SHALL win the first simultaneous request.
REQ-027 Reset asserted mid-transaction or during a pending split SHALL discard the split with no split_grant issued.

Structure
REQ-028 State encodings and NUM_MASTERS SHALL live in the shared bus package alongside the slave-port state constants.
REQ-029 No sub-module is required; the ssplit edge detector is an inline register.

Verification
REQ-030 Reset, then mreq=2'b11 -> mgrant=2'b01 after one cycle; master 0 drops mreq -> mgrant=00 for one cycle, then mgrant=2'b10.
REQ-031 Master 0 granted, ssplit[1] rises -> next cycle mgrant=00 and msplit=2'b01; mreq[1] high -> master 1 granted while msplit stays 01.
REQ-032 Split pending, ssplit[1] falls while master 1 is busy -> no split_grant until mreq[1] drops; then split_grant=3'b010 pulses for one cycle with mgrant=2'b01.
REQ-033 Split pending, ssplit[2] rises -> split_err pulses for one cycle; split_owner and split_slave are unchanged.
REQ-034 Split_ready and mreq[1] both present in IDLE -> SPLIT_RET is taken first; master 1 is granted after master 0 releases.
REQ-035 Assert rstn low mid-split -> all outputs are 0 immediately; the later fall of ssplit produces no split_grant.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: arbiter state encoding, master count, slave-port
// state constants and the round-robin pick helper.
package bus_arbiter_pkg;

  localparam int unsigned NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    SPLIT_RET = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    SLV_IDLE   = 2'd0,
    SLV_ACTIVE = 2'd1,
    SLV_SPLIT  = 2'd2,
    SLV_RETURN = 2'd3
  } slv_state_t;

  // Search starts after the last winner; before any grant it starts at master 0.
  function automatic logic rr_pick(input logic [NUM_MASTERS-1:0] elig,
                                   input logic last, input logic seeded);
    logic first;
    first = seeded ? ~last : 1'b0;
    return elig[first] ? first : ~first;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbitration bundle between the masters/split-capable slaves and the arbiter.
interface bus_arbiter_if #(
  parameter int unsigned NUM_SLAVES = 3
);
  import bus_arbiter_pkg::*;

  logic [NUM_MASTERS-1:0] mreq;
  logic [NUM_MASTERS-1:0] mgrant;
  logic                   msel;
  logic [NUM_MASTERS-1:0] msplit;
  logic [NUM_SLAVES-1:0]  ssplit;
  logic [NUM_SLAVES-1:0]  split_grant;
  logic                   split_err;

  modport master (
    input  mreq, ssplit,
    output mgrant, msel, msplit, split_grant, split_err
  );

  modport slave (
    output mreq, ssplit,
    input  mgrant, msel, msplit, split_grant, split_err
  );

endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with single-outstanding split transaction
// support; all outputs are registered.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 3
) (
  input  logic           clk,
  input  logic           rstn,
  bus_arbiter_if.master  bus
);

  localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [NUM_MASTERS-1:0] MASTER_ONE = NUM_MASTERS'(1);
  localparam logic [NUM_SLAVES-1:0]  SLAVE_ONE  = NUM_SLAVES'(1);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] mgrant_q, mgrant_d;
  logic                   msel_q, msel_d;
  logic [NUM_MASTERS-1:0] msplit_q, msplit_d;
  logic [NUM_SLAVES-1:0]  split_grant_q, split_grant_d;
  logic                   split_err_q, split_err_d;
  logic                   split_pending_q, split_pending_d;
  logic                   split_ready_q, split_ready_d;
  logic                   split_owner_q, split_owner_d;
  logic [SW-1:0]          split_slave_q, split_slave_d;
  logic                   rr_last_q, rr_last_d;
  logic                   rr_seeded_q, rr_seeded_d;
  logic [NUM_SLAVES-1:0]  ssplit_q;

  logic [NUM_SLAVES-1:0]  rise, fall;
  logic [NUM_MASTERS-1:0] mask, elig;
  logic                   pick;
  logic [SW-1:0]          rise_idx;

  assign rise = bus.ssplit & ~ssplit_q;
  assign fall = ~bus.ssplit & ssplit_q;
  assign mask = split_pending_q ? (MASTER_ONE << split_owner_q) : '0;
  assign elig = bus.mreq & ~mask;
  assign pick = rr_pick(elig, rr_last_q, rr_seeded_q);

  always_comb begin
    rise_idx = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (rise[NUM_SLAVES-1-k]) rise_idx = SW'(NUM_SLAVES-1-k);
    end
  end

  always_comb begin
    state_d         = state_q;
    mgrant_d        = mgrant_q;
    msel_d          = msel_q;
    msplit_d        = msplit_q;
    split_grant_d   = '0;
    split_err_d     = split_pending_q && (|rise);
    split_pending_d = split_pending_q;
    split_ready_d   = split_ready_q | (split_pending_q & fall[split_slave_q]);
    split_owner_d   = split_owner_q;
    split_slave_d   = split_slave_q;
    rr_last_d       = rr_last_q;
    rr_seeded_d     = rr_seeded_q;

    case (state_q)
      IDLE: begin
        if (split_ready_q) begin
          state_d = SPLIT_RET;
        end else if (|elig) begin
          mgrant_d    = MASTER_ONE << pick;
          msel_d      = pick;
          rr_last_d   = pick;
          rr_seeded_d = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // A release by the owner ends the transaction, so it outranks a split.
        if (!bus.mreq[msel_q]) begin
          mgrant_d = '0;
          state_d  = IDLE;
        end else if (!split_pending_q && (|rise)) begin
          mgrant_d        = '0;
          msplit_d        = MASTER_ONE << msel_q;
          split_owner_d   = msel_q;
          split_slave_d   = rise_idx;
          split_pending_d = 1'b1;
          state_d         = IDLE;
        end
      end
      SPLIT_RET: begin
        mgrant_d        = MASTER_ONE << split_owner_q;
        msel_d          = split_owner_q;
        rr_last_d       = split_owner_q;
        rr_seeded_d     = 1'b1;
        split_grant_d   = SLAVE_ONE << split_slave_q;
        msplit_d        = '0;
        split_pending_d = 1'b0;
        split_ready_d   = 1'b0;
        state_d         = BUSY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= IDLE;
      mgrant_q        <= '0;
      msel_q          <= 1'b0;
      msplit_q        <= '0;
      split_grant_q   <= '0;
      split_err_q     <= 1'b0;
      split_pending_q <= 1'b0;
      split_ready_q   <= 1'b0;
      split_owner_q   <= 1'b0;
      split_slave_q   <= '0;
      rr_last_q       <= 1'b0;
      rr_seeded_q     <= 1'b0;
      ssplit_q        <= '0;
    end else begin
      state_q         <= state_d;
      mgrant_q        <= mgrant_d;
      msel_q          <= msel_d;
      msplit_q        <= msplit_d;
      split_grant_q   <= split_grant_d;
      split_err_q     <= split_err_d;
      split_pending_q <= split_pending_d;
      split_ready_q   <= split_ready_d;
      split_owner_q   <= split_owner_d;
      split_slave_q   <= split_slave_d;
      rr_last_q       <= rr_last_d;
      rr_seeded_q     <= rr_seeded_d;
      ssplit_q        <= bus.ssplit;
    end
  end

  assign bus.mgrant      = mgrant_q;
  assign bus.msel        = msel_q;
  assign bus.msplit      = msplit_q;
  assign bus.split_grant = split_grant_q;
  assign bus.split_err   = split_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int unsigned NS = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   cmp_on = 1'b0;

  bus_arbiter_if #(.NUM_SLAVES(NS)) bus ();

  bus_arbiter #(.NUM_SLAVES(NS)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: who holds the bus, whether a split return is due, and the one
  // outstanding split (owner, slave, data ready).
  bit [1:0]    e_grant, e_msplit;
  bit          e_sel, e_err;
  bit [NS-1:0] e_sg;
  bit          held, ret_due, have_last, pend, ready;
  int          owner, last, sowner, sslave;
  bit [NS-1:0] prev;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      e_grant = 0; e_msplit = 0; e_sel = 0; e_err = 0; e_sg = 0;
      held = 0; ret_due = 0; have_last = 0; pend = 0; ready = 0;
      owner = 0; last = 0; sowner = 0; sslave = 0; prev = 0;
    end else begin : step
      bit [1:0]    rq;
      bit [NS-1:0] ss, rise, fall;
      bit          nready, done;
      int          first, c, k;
      rq = bus.mreq;
      ss = bus.ssplit;
      rise = ss & ~prev;
      fall = ~ss & prev;
      e_sg = 0;
      e_err = pend && (rise != 0);
      nready = ready || (pend && fall[sslave]);
      if (ret_due) begin
        e_grant = 2'b01 << sowner; e_sel = sowner[0];
        last = sowner; have_last = 1; owner = sowner;
        e_sg = 3'b001 << sslave; e_msplit = 0;
        pend = 0; nready = 0; held = 1; ret_due = 0;
      end else if (held) begin
        if (!rq[owner]) begin
          e_grant = 0; held = 0;
        end else if (!pend && rise != 0) begin
          k = 0;
          while (!rise[k]) k++;
          e_grant = 0; e_msplit = 2'b01 << owner;
          sowner = owner; sslave = k; pend = 1; held = 0;
        end
      end else if (ready) begin
        ret_due = 1;
      end else begin
        first = have_last ? (last + 1) % 2 : 0;
        done = 0;
        for (int i = 0; i < 2; i++) begin
          c = (first + i) % 2;
          if (!done && rq[c] && !(pend && sowner == c)) begin
            e_grant = 2'b01 << c; e_sel = c[0];
            last = c; have_last = 1; owner = c; held = 1; done = 1;
          end
        end
      end
      ready = nready;
      prev = ss;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_mgrant", bus.mgrant, e_grant);
      chk("model_msel", bus.msel, e_sel);
      chk("model_msplit", bus.msplit, e_msplit);
      chk("model_split_grant", bus.split_grant, e_sg);
      chk("model_split_err", bus.split_err, e_err);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.mreq = 0; bus.ssplit = 0;
    repeat (2) cyc();
    cmp_on = 1;
    chk("reset_mgrant", bus.mgrant, 2'b00);
    chk("reset_msplit", bus.msplit, 2'b00);
    chk("reset_split_grant", bus.split_grant, 3'b000);
    rstn = 1;
    cyc();

    // Simultaneous request after reset, then release with turnaround.
    bus.mreq = 2'b11; cyc(); chk("first_grant_m0", bus.mgrant, 2'b01);
    bus.mreq = 2'b10; cyc(); chk("turnaround_gap", bus.mgrant, 2'b00);
    cyc();                   chk("rr_grant_m1", bus.mgrant, 2'b10);
    chk("msel_m1", bus.msel, 1'b1);
    bus.mreq = 2'b00; cyc(); chk("release_m1", bus.mgrant, 2'b00);
    chk("msel_holds", bus.msel, 1'b1);
    cyc();

    // Split of master 0 on slave 1; master 1 runs meanwhile.
    bus.mreq = 2'b01;    cyc(); chk("grant_m0", bus.mgrant, 2'b01);
    bus.ssplit = 3'b010; cyc(); chk("split_clears_grant", bus.mgrant, 2'b00);
    chk("split_msplit", bus.msplit, 2'b01);
    bus.mreq = 2'b11;    cyc(); chk("masked_m0_m1_wins", bus.mgrant, 2'b10);
    chk("msplit_held", bus.msplit, 2'b01);
    bus.ssplit = 3'b110; cyc(); chk("second_split_err", bus.split_err, 1'b1);
    cyc();               chk("err_one_cycle", bus.split_err, 1'b0);
    chk("msplit_after_err", bus.msplit, 2'b01);
    bus.ssplit = 3'b100; cyc(); chk("no_preempt_grant", bus.mgrant, 2'b10);
    chk("no_preempt_sg", bus.split_grant, 3'b000);
    cyc();               chk("still_waiting_sg", bus.split_grant, 3'b000);
    bus.mreq = 2'b01;    cyc(); chk("m1_release", bus.mgrant, 2'b00);
    cyc();               chk("split_ret_cycle", bus.mgrant, 2'b00);
    chk("split_ret_no_sg_yet", bus.split_grant, 3'b000);
    cyc();               chk("split_return_sg", bus.split_grant, 3'b010);
    chk("split_return_grant", bus.mgrant, 2'b01);
    chk("split_return_msplit", bus.msplit, 2'b00);
    cyc();               chk("sg_one_cycle", bus.split_grant, 3'b000);

    // Split return outranks a fresh request from master 1.
    bus.ssplit = 3'b000; cyc();
    bus.ssplit = 3'b001; cyc(); chk("split_s0_msplit", bus.msplit, 2'b01);
    bus.ssplit = 3'b000; cyc(); chk("idle_masked", bus.mgrant, 2'b00);
    bus.mreq = 2'b11;    cyc(); chk("ret_before_m1", bus.mgrant, 2'b00);
    cyc();               chk("ret_grant_m0", bus.mgrant, 2'b01);
    chk("ret_sg_s0", bus.split_grant, 3'b001);
    bus.mreq = 2'b10;    cyc(); chk("m0_release2", bus.mgrant, 2'b00);
    cyc();               chk("m1_after_ret", bus.mgrant, 2'b10);
    bus.mreq = 2'b00;    cyc(); cyc();

    // Reset during a pending split discards it.
    bus.mreq = 2'b01;    cyc(); chk("grant_m0_b", bus.mgrant, 2'b01);
    bus.ssplit = 3'b010; cyc(); chk("split_b", bus.msplit, 2'b01);
    bus.mreq = 2'b00;
    #2 rstn = 0;
    #1;
    chk("async_rst_msplit", bus.msplit, 2'b00);
    chk("async_rst_mgrant", bus.mgrant, 2'b00);
    chk("async_rst_msel", bus.msel, 1'b0);
    cyc(); cyc(); rstn = 1;
    cyc(); bus.ssplit = 3'b000;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("discarded_split_sg", bus.split_grant, 3'b000);
    end

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      cyc();
      for (int m = 0; m < 2; m++)
        if ($urandom_range(7) == 0) bus.mreq[m] = ~bus.mreq[m];
      for (int s = 0; s < int'(NS); s++)
        if ($urandom_range(11) == 0) bus.ssplit[s] = ~bus.ssplit[s];
      if ($urandom_range(1499) == 0) begin
        #2 rstn = 0;
        cyc();
        rstn = 1;
      end
    end

    cyc();
    cmp_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
